// File: rtl/dsm_pkg.sv
// Shared definitions for the DSM multi-modulus divider: ratio limits,
// FSM state encoding and ratio clamp/range helpers.
package dsm_pkg;

    localparam int unsigned RATIO_W = 4;

    localparam logic [RATIO_W-1:0] MIN_RATIO = RATIO_W'(5);
    localparam logic [RATIO_W-1:0] MAX_RATIO = RATIO_W'(12);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Force a DSM ratio into the legal MIN_RATIO..MAX_RATIO band.
    function automatic logic [RATIO_W-1:0] clamp_ratio(input logic [RATIO_W-1:0] r);
        logic [RATIO_W-1:0] res;
        res = r;
        if (r < MIN_RATIO) begin
            res = MIN_RATIO;
        end else if (r > MAX_RATIO) begin
            res = MAX_RATIO;
        end
        return res;
    endfunction

    // True when a DSM ratio lies outside the legal band.
    function automatic logic ratio_bad(input logic [RATIO_W-1:0] r);
        return (r < MIN_RATIO) || (r > MAX_RATIO);
    endfunction

endpackage

// File: rtl/dsm_win_meter.sv
// Window meter: counts pulse events over 2^WIN_LOG2 consecutive run cycles
// and publishes the count with a one-cycle valid strobe.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   run         meter active this cycle; low discards the partial window
//   pulse       event to count this cycle
//   win_cnt     count of the last complete window
//   win_valid   one-cycle strobe marking a fresh win_cnt
module dsm_win_meter #(
    parameter int unsigned WIN_LOG2 = 10,
    parameter int unsigned CNT_W    = WIN_LOG2 + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             pulse,
    output logic [CNT_W-1:0] win_cnt,
    output logic             win_valid
);

    logic [WIN_LOG2-1:0] wcnt;
    logic [CNT_W-1:0]    acc;

    // A pulse in the last window cycle is folded into the ending window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt      <= '0;
            acc       <= '0;
            win_cnt   <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            if (!run) begin
                wcnt <= '0;
                acc  <= '0;
            end else begin
                wcnt <= wcnt + WIN_LOG2'(1);
                if (&wcnt) begin
                    win_cnt   <= acc + CNT_W'(pulse);
                    win_valid <= 1'b1;
                    acc       <= '0;
                end else begin
                    acc <= acc + CNT_W'(pulse);
                end
            end
        end
    end

endmodule

// File: rtl/dsm_mmd.sv
// Multi-modulus divider behind the DSM: divides clk by a ratio (5..12)
// taken from the DSM once per output period, plus a pulse window meter.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   en          divider enable; low returns to IDLE
//   div_in      ratio from the DSM
//   clr_err     synchronous clear of err_range
//   div_take    ratio sampled at the coming edge (DSM advance strobe)
//   div_out     one-cycle pulse per divided period
//   div_clk     divided clock, ceil(R/2) high / floor(R/2) low
//   cur_ratio   ratio of the period in progress
//   err_range   sticky out-of-range flag
//   win_cnt     div_out pulses in the last complete window
//   win_valid   one-cycle strobe marking a new win_cnt
module dsm_mmd
    import dsm_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = 10,
    parameter int unsigned CNT_W    = WIN_LOG2 + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [RATIO_W-1:0] div_in,
    input  logic               clr_err,
    output logic               div_take,
    output logic               div_out,
    output logic               div_clk,
    output logic [RATIO_W-1:0] cur_ratio,
    output logic               err_range,
    output logic [CNT_W-1:0]   win_cnt,
    output logic               win_valid
);

    state_t             state_q, state_d;
    logic [RATIO_W-1:0] cnt_q, cnt_d;
    logic [RATIO_W-1:0] ratio_d;
    logic [RATIO_W-1:0] ratio_ld;
    logic               div_clk_d;
    logic               err_d;
    logic               run;

    assign ratio_ld = clamp_ratio(div_in);
    assign run      = (state_q == RUN) && en;

    // State, down-counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_ratio <= '0;
            div_clk   <= 1'b0;
            err_range <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_ratio <= ratio_d;
            div_clk   <= div_clk_d;
            err_range <= err_d;
        end
    end

    // Next-state, ratio reload and strobe decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ratio_d  = cur_ratio;
        div_take = 1'b0;
        div_out  = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    div_take = 1'b1;
                    state_d  = RUN;
                    ratio_d  = ratio_ld;
                    cnt_d    = ratio_ld - RATIO_W'(1);
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    // Reload in the pulse cycle so periods abut with no dead cycle.
                    div_out  = 1'b1;
                    div_take = 1'b1;
                    ratio_d  = ratio_ld;
                    cnt_d    = ratio_ld - RATIO_W'(1);
                end else begin
                    cnt_d = cnt_q - RATIO_W'(1);
                end
            end
        endcase

        // div_clk is precomputed from the next counter value so it leaves a flop.
        div_clk_d = (state_d == RUN) && (cnt_d >= (ratio_d >> 1));

        // A new violation takes priority over a same-cycle clear.
        err_d = err_range;
        if (div_take && ratio_bad(div_in)) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    dsm_win_meter #(
        .WIN_LOG2 (WIN_LOG2),
        .CNT_W    (CNT_W)
    ) u_win_meter (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .pulse     (div_out),
        .win_cnt   (win_cnt),
        .win_valid (win_valid)
    );

endmodule

// File: tb/tb_dsm_mmd.sv
// Self-checking bench for dsm_mmd: table of ratio sequences, directed
// corner sequences and randomized traffic against a period-position model.
module tb_dsm_mmd;

    localparam int WIN_LOG2 = 10;
    localparam int CNT_W    = WIN_LOG2 + 1;
    localparam int WIN      = 1 << WIN_LOG2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [3:0]       div_in;
    logic             clr_err;
    logic             div_take;
    logic             div_out;
    logic             div_clk;
    logic [3:0]       cur_ratio;
    logic             err_range;
    logic [CNT_W-1:0] win_cnt;
    logic             win_valid;

    dsm_mmd #(
        .WIN_LOG2 (WIN_LOG2),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .div_in    (div_in),
        .clr_err   (clr_err),
        .div_take  (div_take),
        .div_out   (div_out),
        .div_clk   (div_clk),
        .cur_ratio (cur_ratio),
        .err_range (err_range),
        .win_cnt   (win_cnt),
        .win_valid (win_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: position p inside a period of length m_r; pulse at p == m_r-1.
    bit m_run;
    int m_p, m_r, m_err, m_wcnt, m_wvalid, m_wstart;
    int pq[$];

    // Sampled DUT outputs of the most recent cycle.
    int s_take, s_out, s_clk, s_ratio, s_err, s_wcnt, s_valid;

    typedef struct {
        logic [3:0] din;
        int         period;
    } vec_t;
    vec_t vt[9];

    function automatic int clampi(input int d);
        if (d < 5)  return 5;
        if (d > 12) return 12;
        return d;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_win(input string name, input int act);
        total++;
        if (act != 157 && act != 158) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s cycle=%0d got=%0d want=157..158", name, cyc, act);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_p = 0; m_r = 0; m_err = 0;
        m_wcnt = 0; m_wvalid = 0; m_wstart = 0;
        pq.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_take"},  int'(div_take),  0);
        chk({tag, "_out"},   int'(div_out),   0);
        chk({tag, "_clk"},   int'(div_clk),   0);
        chk({tag, "_ratio"}, int'(cur_ratio), 0);
        chk({tag, "_err"},   int'(err_range), 0);
        chk({tag, "_wcnt"},  int'(win_cnt),   0);
        chk({tag, "_wvld"},  int'(win_valid), 0);
    endtask

    // One clock cycle: drive, sample, compare with model, advance model.
    task automatic cycle(input bit e, input int d, input bit c);
        bit last, take, out;
        int n;
        @(negedge clk);
        en = e; div_in = 4'(d); clr_err = c;
        #1;
        s_take = int'(div_take); s_out = int'(div_out); s_clk = int'(div_clk);
        s_ratio = int'(cur_ratio); s_err = int'(err_range);
        s_wcnt = int'(win_cnt); s_valid = int'(win_valid);

        last = m_run && (m_p == m_r - 1);
        take = e && (!m_run || last);
        out  = e && last;
        chk("div_take",  s_take,  int'(take));
        chk("div_out",   s_out,   int'(out));
        chk("div_clk",   s_clk,   int'(m_run && (m_p < (m_r + 1) / 2)));
        chk("cur_ratio", s_ratio, m_r);
        chk("err_range", s_err,   m_err);
        chk("win_cnt",   s_wcnt,  m_wcnt);
        chk("win_valid", s_valid, m_wvalid);

        // Window: count pulse times falling inside the last WIN run cycles.
        m_wvalid = 0;
        if (m_run && e) begin
            if (out) pq.push_back(cyc);
            if ((cyc - m_wstart) % WIN == WIN - 1) begin
                n = 0;
                foreach (pq[i]) if (pq[i] > cyc - WIN) n++;
                m_wcnt = n; m_wvalid = 1;
                pq.delete();
            end
        end else begin
            pq.delete();
            m_wstart = cyc + 1;
        end

        if (take && (d < 5 || d > 12)) m_err = 1;
        else if (c)                    m_err = 0;

        if (!e) begin
            m_run = 0; m_p = 0;
        end else if (take) begin
            m_run = 1; m_r = clampi(d); m_p = 0;
        end else begin
            m_p++;
        end
        cyc++;
    endtask

    initial begin
        int idx, last_take, lo, nv, nv_late, tog, got, pt;

        vt[0] = '{4'd5,  5};
        vt[1] = '{4'd12, 12};
        vt[2] = '{4'd7,  7};
        vt[3] = '{4'd3,  5};
        vt[4] = '{4'd15, 12};
        vt[5] = '{4'd0,  5};
        vt[6] = '{4'd13, 12};
        vt[7] = '{4'd8,  8};
        vt[8] = '{4'd9,  9};

        rst_n = 1'b1; en = 1'b0; div_in = '0; clr_err = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_zero("reset");
        rst_n = 1'b1;

        // Ratio table: each entry presented on its take; gap to the next take checked.
        idx = 0; last_take = -1;
        for (int b = 0; b < 400 && idx < 9; b++) begin
            cycle(1, int'(vt[idx].din), 0);
            if (s_take != 0) begin
                if (idx > 0) begin
                    chk("tbl_period", (cyc - 1) - last_take, vt[idx - 1].period);
                    chk("tbl_ratio",  s_ratio, vt[idx - 1].period);
                end
                last_take = cyc - 1;
                idx++;
            end
        end
        chk("tbl_done", idx, 9);

        // Constant ratio 8 from a fresh start: gaps of 8, windows of 128.
        cycle(0, 8, 1); cycle(0, 8, 0);
        lo = -1; nv = 0;
        for (int i = 0; i < 2500; i++) begin
            cycle(1, 8, 0);
            if (s_out != 0) begin
                if (lo >= 0) chk("gap8", (cyc - 1) - lo, 8);
                lo = cyc - 1;
            end
            if (s_valid != 0) begin
                chk("win8", s_wcnt, 128);
                nv++;
            end
        end
        chk("win8_count", nv, 2);

        // Asynchronous reset in the middle of a window.
        @(posedge clk);
        #2 rst_n = 1'b0; en = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nv = 0; nv_late = 0;
        for (int i = 0; i < 1030; i++) begin
            cycle(1, 8, 0);
            if (s_valid != 0) begin
                if (i < 1024) nv++;
                else          nv_late++;
            end
        end
        chk("no_early_valid", nv, 0);
        chk("valid_after_rst", nv_late, 1);

        // Fractional 6/7 alternation: windows hold 157 or 158 pulses.
        cycle(0, 6, 0); cycle(0, 6, 0);
        tog = 0; nv = 0;
        for (int i = 0; i < 4200; i++) begin
            cycle(1, (tog != 0) ? 7 : 6, 0);
            if (s_take != 0) tog = 1 - tog;
            if (s_valid != 0) begin
                chk_win("win_frac", s_wcnt);
                nv++;
            end
        end
        chk("frac_windows", nv, 4);

        // Drop en when the divider counter holds 3, then re-enable.
        got = 0;
        for (int k = 0; k < 40 && got == 0; k++) begin
            if (m_run && m_p == m_r - 4) got = 1;
            else cycle(1, 8, 0);
        end
        chk("endrop_reached", got, 1);
        cycle(0, 8, 0);
        chk("endrop_no_out", s_out, 0);
        cycle(0, 8, 0);
        chk("idle_clk",  s_clk,   0);
        chk("idle_out",  s_out,   0);
        chk("idle_wvld", s_valid, 0);
        chk("idle_take", s_take,  0);
        cycle(1, 8, 0);
        chk("reen_take", s_take, 1);
        for (int i = 0; i < 20; i++) cycle(1, 8, 0);

        // Sticky error: set on 3, held through a same-cycle clear on 15, then cleared.
        cycle(0, 0, 1); cycle(0, 0, 0);
        chk("err_pre", s_err, 0);
        cycle(1, 3, 0);
        cycle(1, 15, 0);
        chk("err_set", s_err, 1);
        chk("err_ratio5", s_ratio, 5);
        got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            pt = int'(m_run && (m_p == m_r - 1));
            cycle(1, 15, pt != 0);
            if (pt != 0) got = 1;
        end
        chk("err_take_seen", got, 1);
        cycle(1, 8, 0);
        chk("err_set_wins", s_err, 1);
        chk("err_ratio12", s_ratio, 12);
        cycle(1, 8, 1);
        cycle(1, 8, 0);
        chk("err_cleared", s_err, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 40) != 0, int'($urandom % 16), ($urandom % 16) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
